// File: rtl/loop_detect_engine.sv
// Combinational-loop detector for a directed driver->load graph.
// Edges are streamed into an adjacency matrix while IDLE. An iterative DFS with
// white/grey/black colouring then examines one adjacency bit per cycle.
//
// state  | meaning
// IDLE   | accepts edges, clear and start
// SCAN   | looks for the next white root v in ascending order
// DFS    | examines adj[top][ptr[top]], pushing or popping as needed
// FINISH | one-cycle done pulse, then back to IDLE
module loop_detect_engine #(
  parameter  int NODES = 16,
  localparam int NW    = $clog2(NODES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          edge_valid,
  output logic          edge_ready,
  input  logic [NW-1:0] edge_src,
  input  logic [NW-1:0] edge_dst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          loop_found,
  output logic [NW-1:0] loop_node
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DFS, S_FINISH} state_t;

  localparam logic [1:0]    WHITE = 2'd0;
  localparam logic [1:0]    GREY  = 2'd1;
  localparam logic [1:0]    BLACK = 2'd2;
  localparam logic [NW-1:0] LAST  = NW'(NODES - 1);

  state_t                     state_q, state_d;
  logic [NODES-1:0][NODES-1:0] adj_q, adj_d;
  logic [NODES-1:0][1:0]       col_q, col_d;
  logic [NODES-1:0][NW-1:0]    stk_q, stk_d;
  // One extra bit so a node whose last child was NODES-1 can be seen as exhausted.
  logic [NODES-1:0][NW:0]      ptr_q, ptr_d;
  logic [NW:0]                 sp_q, sp_d;
  logic [NW-1:0]               v_q, v_d;
  logic                        lf_q, lf_d;
  logic [NW-1:0]               ln_q, ln_d;

  logic [NW-1:0] u;
  logic [NW-1:0] w;
  logic          exhausted;
  logic          hit;

  assign u          = stk_q[NW'(sp_q - (NW+1)'(1))];
  assign w          = ptr_q[u][NW-1:0];
  assign exhausted  = ptr_q[u][NW];
  assign hit        = !exhausted && adj_q[u][w];

  assign edge_ready = (state_q == S_IDLE) && !clear;
  assign busy       = (state_q == S_SCAN) || (state_q == S_DFS);
  assign done       = (state_q == S_FINISH);
  assign loop_found = lf_q;
  assign loop_node  = ln_q;

  // Next-state and datapath updates for the search FSM.
  always_comb begin
    state_d = state_q;
    adj_d   = adj_q;
    col_d   = col_q;
    stk_d   = stk_q;
    ptr_d   = ptr_q;
    sp_d    = sp_q;
    v_d     = v_q;
    lf_d    = lf_q;
    ln_d    = ln_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          adj_d = '0;
          lf_d  = 1'b0;
          ln_d  = '0;
        end else if (edge_valid) begin
          adj_d[edge_src][edge_dst] = 1'b1;
        end
        if (start) begin
          state_d = S_SCAN;
          v_d     = '0;
          col_d   = '0;
          sp_d    = '0;
          lf_d    = 1'b0;
          ln_d    = '0;
        end
      end
      S_SCAN: begin
        if (col_q[v_q] == WHITE) begin
          col_d[v_q]              = GREY;
          stk_d[sp_q[NW-1:0]]     = v_q;
          sp_d                    = sp_q + (NW+1)'(1);
          ptr_d[v_q]              = '0;
          state_d                 = S_DFS;
        end else if (v_q == LAST) begin
          state_d = S_FINISH;
        end else begin
          v_d = v_q + NW'(1);
        end
      end
      S_DFS: begin
        if (hit && col_q[w] == GREY) begin
          lf_d    = 1'b1;
          ln_d    = w;
          state_d = S_FINISH;
        end else if (hit && col_q[w] == WHITE) begin
          col_d[w]            = GREY;
          stk_d[sp_q[NW-1:0]] = w;
          sp_d                = sp_q + (NW+1)'(1);
          ptr_d[u]            = ptr_q[u] + (NW+1)'(1);
          ptr_d[w]            = '0;
        end else if (exhausted || w == LAST) begin
          col_d[u] = BLACK;
          sp_d     = sp_q - (NW+1)'(1);
          if (sp_q == (NW+1)'(1)) begin
            if (v_q == LAST) begin
              state_d = S_FINISH;
            end else begin
              v_d     = v_q + NW'(1);
              state_d = S_SCAN;
            end
          end
        end else begin
          ptr_d[u] = ptr_q[u] + (NW+1)'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      adj_q   <= '0;
      col_q   <= '0;
      stk_q   <= '0;
      ptr_q   <= '0;
      sp_q    <= '0;
      v_q     <= '0;
      lf_q    <= 1'b0;
      ln_q    <= '0;
    end else begin
      state_q <= state_d;
      adj_q   <= adj_d;
      col_q   <= col_d;
      stk_q   <= stk_d;
      ptr_q   <= ptr_d;
      sp_q    <= sp_d;
      v_q     <= v_d;
      lf_q    <= lf_d;
      ln_q    <= ln_d;
    end
  end

endmodule

// File: tb/tb_loop_detect_engine.sv
// Bench for loop_detect_engine: directed graphs with known answers plus a few
// random graphs checked against a small reference DFS.
module tb_loop_detect_engine;

  localparam int NODES = 16;
  localparam int NW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          edge_valid;
  logic          edge_ready;
  logic [NW-1:0] edge_src;
  logic [NW-1:0] edge_dst;
  logic          start;
  logic          busy;
  logic          done;
  logic          loop_found;
  logic [NW-1:0] loop_node;

  loop_detect_engine #(.NODES(NODES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .edge_valid (edge_valid),
    .edge_ready (edge_ready),
    .edge_src   (edge_src),
    .edge_dst   (edge_dst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .loop_found (loop_found),
    .loop_node  (loop_node)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [NODES-1:0][NODES-1:0] adj_m;
  logic [NW:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference DFS: ascending roots, ascending neighbours, first grey hit wins.
  function automatic logic [NW:0] model(input logic [NODES-1:0][NODES-1:0] a);
    int col[NODES];
    int ptr[NODES];
    int stk[NODES];
    int sp;
    int uu;
    int ww;
    for (int i = 0; i < NODES; i++) begin
      col[i] = 0;
      ptr[i] = 0;
    end
    for (int v = 0; v < NODES; v++) begin
      if (col[v] == 0) begin
        col[v] = 1; stk[0] = v; sp = 1; ptr[v] = 0;
        while (sp > 0) begin
          uu = stk[sp-1];
          if (ptr[uu] >= NODES) begin
            col[uu] = 2;
            sp--;
          end else begin
            ww = ptr[uu];
            ptr[uu]++;
            if (a[uu][ww]) begin
              if (col[ww] == 1) return {1'b1, NW'(ww)};
              if (col[ww] == 0) begin
                col[ww] = 1; ptr[ww] = 0; stk[sp] = ww; sp++;
              end
            end
          end
        end
      end
    end
    return '0;
  endfunction

  task automatic add_edge(input int s, input int d);
    @(negedge clk);
    edge_valid = 1'b1;
    edge_src   = NW'(s);
    edge_dst   = NW'(d);
    if (edge_ready) adj_m[s][d] = 1'b1;
    @(negedge clk);
    edge_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear      = 1'b1;
    edge_valid = 1'b1;
    edge_src   = 4'd5;
    edge_dst   = 4'd5;
    #1;
    check("clear_edge_ready", 32'(edge_ready), 32'd0);
    @(negedge clk);
    clear      = 1'b0;
    edge_valid = 1'b0;
    adj_m      = '0;
    check("clear_loop_found", 32'(loop_found), 32'd0);
    check("clear_loop_node", 32'(loop_node), 32'd0);
  endtask

  task automatic run_search(input string tag, input bit use_model, input bit exp_lf,
                            input int exp_ln, input bit poke_busy);
    logic [NW:0] e;
    int  cyc;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    if (use_model) sb_q.push_back(model(adj_m));
    else           sb_q.push_back({exp_lf, NW'(exp_ln)});
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    seen  = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!seen && cyc < 400) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        start = (poke_busy && cyc == 10);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = sb_q.pop_front();
    if (seen) begin
      check({tag, "_loop_found"}, 32'(loop_found), 32'(e[NW]));
      check({tag, "_loop_node"}, 32'(loop_node), 32'(e[NW-1:0]));
      check({tag, "_latency_ok"}, 32'(cyc <= NODES*NODES + 3*NODES + 4), 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_result_hold"}, 32'({loop_found, loop_node}), 32'(e));
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; edge_valid = 1'b0; edge_src = '0; edge_dst = '0; start = 1'b0;
    adj_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_loop_found", 32'(loop_found), 32'd0);
    check("rst_loop_node", 32'(loop_node), 32'd0);
    check("rst_edge_ready", 32'(edge_ready), 32'd1);

    add_edge(0, 1); add_edge(1, 2); add_edge(2, 3); add_edge(3, 0);
    run_search("ring", 1'b0, 1'b1, 0, 1'b1);
    do_clear();

    add_edge(0, 1); add_edge(1, 2); add_edge(0, 2); add_edge(0, 2);
    run_search("dag", 1'b0, 1'b0, 0, 1'b0);
    do_clear();

    add_edge(5, 5);
    run_search("self", 1'b0, 1'b1, 5, 1'b0);
    do_clear();

    add_edge(0, 1); add_edge(3, 4); add_edge(4, 3);
    run_search("late_root", 1'b0, 1'b1, 3, 1'b0);
    do_clear();

    for (int i = 0; i < 8; i++) add_edge(i, i + 1);
    add_edge(8, 0);
    add_edge(6, 10); add_edge(10, 11); add_edge(11, 12); add_edge(12, 1);
    run_search("ring9", 1'b0, 1'b1, 0, 1'b0);
    do_clear();
    for (int i = 0; i < 8; i++) add_edge(i, i + 1);
    add_edge(6, 10); add_edge(10, 11); add_edge(11, 12); add_edge(12, 1);
    run_search("chord", 1'b0, 1'b1, 1, 1'b0);
    do_clear();

    // Edge offered together with start is visible to the search.
    @(negedge clk);
    edge_valid = 1'b1; edge_src = 4'd7; edge_dst = 4'd7;
    adj_m[7][7] = 1'b1;
    start = 1'b1;
    sb_q.push_back({1'b1, 4'd7});
    @(negedge clk);
    edge_valid = 1'b0; start = 1'b0;
    begin
      int  cyc;
      logic [NW:0] e;
      cyc = 0;
      while (!done && cyc < 400) begin @(negedge clk); cyc++; end
      check("edge_with_start_done", 32'(done), 32'd1);
      e = sb_q.pop_front();
      check("edge_with_start_result", 32'({loop_found, loop_node}), 32'(e));
    end
    do_clear();

    // Random graphs against the reference model.
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 6 + g * 3; k++)
        add_edge(int'($urandom_range(NODES - 1)), int'($urandom_range(NODES - 1)));
      run_search($sformatf("rand%0d", g), 1'b1, 1'b0, 0, 1'b0);
      do_clear();
    end

    // Reset mid-search aborts with no done pulse and an empty matrix.
    add_edge(0, 1); add_edge(1, 2); add_edge(2, 0);
    add_edge(3, 4);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    adj_m = '0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_edge_ready", 32'(edge_ready), 32'd1);
    begin
      bit saw_done;
      saw_done = 1'b0;
      repeat (350) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
    end
    run_search("after_abort", 1'b0, 1'b0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
